cpu_fetch: RTL and testbench



---
 rtl/cpu_pkg.sv | 15 +
 rtl/cpu_fetch_skid.sv | 36 +++
 rtl/cpu_fetch.sv | 121 ++++++++++++
 tb/tb_cpu_fetch.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and defaults for the 16-bit pipelined CPU.
package cpu_pkg;

    localparam int unsigned DEFAULT_WIDTH             = 16;
    localparam int unsigned DEFAULT_INSTRUCTION_WIDTH = 24;
    localparam int unsigned DEFAULT_OPCODE_WIDTH      = 4;

    localparam logic [3:0] HALT_OPCODE = 4'b1111;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/cpu_fetch_skid.sv
// One-entry {instruction, pc} buffer that catches an in-flight fetch while decode stalls.
module cpu_fetch_skid
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH            = DEFAULT_WIDTH,
    parameter int unsigned INSTRUCTIONWIDTH = DEFAULT_INSTRUCTION_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        clear,
    input  logic [INSTRUCTIONWIDTH-1:0] instrIn,
    input  logic [WIDTH-1:0]            pcIn,
    output logic                        valid,
    output logic [INSTRUCTIONWIDTH-1:0] instrOut,
    output logic [WIDTH-1:0]            pcOut
);

    always_ff @(posedge clk) begin
        if (reset) begin
            valid    <= 1'b0;
            instrOut <= '0;
            pcOut    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (push) begin
            valid    <= 1'b1;
            instrOut <= instrIn;
            pcOut    <= pcIn;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// Fetch stage: sequential PC issue into synchronous imem, skid-buffered hand-off to decode,
// branch redirect and HALT parking.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned WIDTH            = DEFAULT_WIDTH,
    parameter int unsigned INSTRUCTIONWIDTH = DEFAULT_INSTRUCTION_WIDTH,
    parameter int unsigned OPCODEWIDTH      = DEFAULT_OPCODE_WIDTH
) (
    input  logic                        clk,
    input  logic                        reset,
    output logic [WIDTH-1:0]            imemAddressF,
    output logic                        imemReadEnableF,
    input  logic [INSTRUCTIONWIDTH-1:0] imemDataF,
    input  logic                        PCSelectorF,
    input  logic [WIDTH-1:0]            branchTargetF,
    input  logic                        stallD,
    output logic [INSTRUCTIONWIDTH-1:0] InstructionD,
    output logic [WIDTH-1:0]            PCD,
    output logic                        validD,
    output logic                        haltF
);

    fetch_state_t state, nextState;

    logic [WIDTH-1:0]            pcF;
    logic [WIDTH-1:0]            reqPc;
    logic                        inflight;
    logic                        issue;
    logic                        arrivalValid;
    logic                        arrivalIsHalt;
    logic                        outFree;
    logic                        toOutput;
    logic                        skidPush;
    logic                        skidPop;
    logic                        skidValid;
    logic [INSTRUCTIONWIDTH-1:0] skidInstr;
    logic [WIDTH-1:0]            skidPc;

    always_comb begin
        outFree       = !validD || !stallD;
        issue         = !reset && (state == RUN) && !skidValid && !(validD && stallD) && !PCSelectorF;
        // Arrivals landing in the first HALTED cycle belong to the word after HALT: drop them.
        arrivalValid  = inflight && (state == RUN) && !PCSelectorF;
        arrivalIsHalt = imemDataF[INSTRUCTIONWIDTH-1 -: OPCODEWIDTH] == OPCODEWIDTH'(HALT_OPCODE);
        toOutput      = arrivalValid && outFree && !skidValid;
        skidPush      = arrivalValid && !toOutput;
        skidPop       = outFree && skidValid && !PCSelectorF;

        nextState = state;
        if (PCSelectorF) begin
            nextState = RUN;
        end else if (arrivalValid && arrivalIsHalt) begin
            nextState = HALTED;
        end
    end

    assign imemAddressF    = pcF;
    assign imemReadEnableF = issue;
    assign haltF           = (state == HALTED);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pcF          <= '0;
            reqPc        <= '0;
            inflight     <= 1'b0;
            InstructionD <= '0;
            PCD          <= '0;
            validD       <= 1'b0;
        end else begin
            inflight <= issue;
            if (PCSelectorF) begin
                pcF <= branchTargetF;
            end else if (issue) begin
                pcF   <= pcF + WIDTH'(1);
                reqPc <= pcF;
            end

            if (PCSelectorF) begin
                validD <= 1'b0;
            end else if (outFree) begin
                if (skidValid) begin
                    InstructionD <= skidInstr;
                    PCD          <= skidPc;
                    validD       <= 1'b1;
                end else if (arrivalValid) begin
                    InstructionD <= imemDataF;
                    PCD          <= reqPc;
                    validD       <= 1'b1;
                end else begin
                    validD <= 1'b0;
                end
            end
        end
    end

    cpu_fetch_skid #(
        .WIDTH            (WIDTH),
        .INSTRUCTIONWIDTH (INSTRUCTIONWIDTH)
    ) skid (
        .clk      (clk),
        .reset    (reset),
        .push     (skidPush),
        .pop      (skidPop),
        .clear    (PCSelectorF),
        .instrIn  (imemDataF),
        .pcIn     (reqPc),
        .valid    (skidValid),
        .instrOut (skidInstr),
        .pcOut    (skidPc)
    );

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed bench for cpu_fetch: table-driven stream/stall run plus redirect, halt, wrap and reset sequences.
module tb_cpu_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] imemAddressF;
    logic        imemReadEnableF;
    logic [23:0] imemDataF = '0;
    logic        PCSelectorF = 1'b0;
    logic [15:0] branchTargetF = '0;
    logic        stallD = 1'b0;
    logic [23:0] InstructionD;
    logic [15:0] PCD;
    logic        validD;
    logic        haltF;

    int checks = 0;
    int passes = 0;
    logic haltEn = 1'b0;

    typedef struct {
        logic        stall;
        logic        sel;
        logic [15:0] tgt;
        logic        expValid;
        logic [15:0] expPcd;
        logic        expRe;
        logic        expHalt;
    } vec_t;

    vec_t vecs[13];

    cpu_fetch #(
        .WIDTH            (16),
        .INSTRUCTIONWIDTH (24),
        .OPCODEWIDTH      (4)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imemAddressF    (imemAddressF),
        .imemReadEnableF (imemReadEnableF),
        .imemDataF       (imemDataF),
        .PCSelectorF     (PCSelectorF),
        .branchTargetF   (branchTargetF),
        .stallD          (stallD),
        .InstructionD    (InstructionD),
        .PCD             (PCD),
        .validD          (validD),
        .haltF           (haltF)
    );

    always #5 clk = ~clk;

    // Word i is {0011, i}; address 4 becomes HALT while haltEn is set.
    function automatic logic [23:0] wordAt(input logic [15:0] a, input logic hEn);
        if (hEn && a == 16'h0004) return 24'hF00000;
        return {4'b0011, 4'b0000, a};
    endfunction

    always @(posedge clk) begin
        if (imemReadEnableF) imemDataF <= wordAt(imemAddressF, haltEn);
    end

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cycle(input logic rst, input logic st, input logic sel, input logic [15:0] tgt);
        @(posedge clk);
        #1;
        reset = rst; stallD = st; PCSelectorF = sel; branchTargetF = tgt;
        @(negedge clk);
        if (!reset && dut.inflight && dut.skidValid) begin
            checks++;
            $display("FAIL invariant: arrival with full skid at %0t", $time);
        end
    endtask

    task automatic expectOut(input string tag, input logic v, input logic [15:0] pcd,
                             input logic re, input logic h);
        cmp({tag, " validD"}, 32'(validD), 32'(v));
        cmp({tag, " readEnable"}, 32'(imemReadEnableF), 32'(re));
        cmp({tag, " haltF"}, 32'(haltF), 32'(h));
        if (v) begin
            cmp({tag, " PCD"}, 32'(PCD), 32'(pcd));
            cmp({tag, " InstructionD"}, 32'(InstructionD), 32'(wordAt(pcd, haltEn)));
        end
    endtask

    task automatic checkReset(input string tag);
        cmp({tag, " validD"}, 32'(validD), 32'd0);
        cmp({tag, " PCD"}, 32'(PCD), 32'd0);
        cmp({tag, " InstructionD"}, 32'(InstructionD), 32'd0);
        cmp({tag, " readEnable"}, 32'(imemReadEnableF), 32'd0);
        cmp({tag, " haltF"}, 32'(haltF), 32'd0);
    endtask

    task automatic doReset();
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0);
        checkReset("reset");
    endtask

    initial begin
        // Cycle-by-cycle stream from reset release (cycle 0), stall held in cycles 4..6.
        vecs[0]  = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h1, 1'b1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h2, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h3, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h4, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h5, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 16'h0, 1'b1, 16'h6, 1'b1, 1'b0};

        doReset();
        for (int i = 0; i < 13; i++) begin
            cycle(1'b0, vecs[i].stall, vecs[i].sel, vecs[i].tgt);
            expectOut($sformatf("stream c%0d", i), vecs[i].expValid, vecs[i].expPcd,
                      vecs[i].expRe, vecs[i].expHalt);
        end

        // Redirect in cycle 5 to 0x0040.
        doReset();
        for (int c = 0; c < 5; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0);
            expectOut($sformatf("redir c%0d", c), c >= 2, 16'(c - 2), 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h0040); expectOut("redir c5", 1'b1, 16'h0003, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("redir c6", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("redir c7", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("redir c8", 1'b1, 16'h0040, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("redir c9", 1'b1, 16'h0041, 1'b1, 1'b0);

        // HALT at word 4, park 10 cycles, resume at 0x0010, then wrap from 0xFFFE.
        haltEn = 1'b1;
        doReset();
        for (int c = 0; c < 6; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0);
            expectOut($sformatf("halt c%0d", c), c >= 2, 16'(c - 2), 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b0, 1'b0, 16'h0); expectOut("halt c6", 1'b1, 16'h0004, 1'b0, 1'b1);
        for (int c = 7; c < 17; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0);
            expectOut($sformatf("parked c%0d", c), 1'b0, 16'h0, 1'b0, 1'b1);
        end
        cycle(1'b0, 1'b0, 1'b1, 16'h0010); expectOut("resume c17", 1'b0, 16'h0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("resume c18", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("resume c19", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("resume c20", 1'b1, 16'h0010, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFE); expectOut("wrap c21", 1'b1, 16'h0011, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("wrap c22", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("wrap c23", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("wrap c24", 1'b1, 16'hFFFE, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("wrap c25", 1'b1, 16'hFFFF, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0);    expectOut("wrap c26", 1'b1, 16'h0000, 1'b1, 1'b0);
        haltEn = 1'b0;

        // Reset while stalled with the skid full, then restart.
        doReset();
        for (int c = 0; c < 4; c++) begin
            cycle(1'b0, 1'b0, 1'b0, 16'h0);
            expectOut($sformatf("rst c%0d", c), c >= 2, 16'(c - 2), 1'b1, 1'b0);
        end
        cycle(1'b0, 1'b1, 1'b0, 16'h0); expectOut("rst c4", 1'b1, 16'h0002, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 16'h0); expectOut("rst c5", 1'b1, 16'h0002, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0); checkReset("midreset");
        cycle(1'b0, 1'b0, 1'b0, 16'h0); expectOut("restart c0", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0); expectOut("restart c1", 1'b0, 16'h0, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0); expectOut("restart c2", 1'b1, 16'h0000, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 16'h0); expectOut("restart c3", 1'b1, 16'h0001, 1'b1, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
